memory_pairs_shuffler: RTL and testbench

MEMORY_PAIRS_SHUFFLER -- requirements
Module: memory_pairs_shuffler

---
 rtl/memory_pairs_pkg.sv | 24 ++
 rtl/memory_lfsr.sv | 33 +++
 rtl/memory_pairs_shuffler.sv | 84 ++++++++
 tb/tb_memory_pairs_shuffler.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/memory_pairs_pkg.sv
// Shared constants, FSM encoding and elaboration helpers for the memory-pairs shuffler.
package memory_pairs_pkg;

    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    typedef enum logic {
        ST_SHUFFLE = 1'b0,
        ST_DONE    = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result++;
            v = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/memory_lfsr.sv
// 16-bit right-shifting Galois LFSR; free-running, reloads SEED on reset.
module memory_lfsr
    import memory_pairs_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] q
);

    logic [15:0] q_q;
    logic [15:0] q_d;

    always_comb begin
        q_d = {1'b0, q_q[15:1]};
        if (q_q[0]) begin
            q_d = q_d ^ LFSR_TAPS;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/memory_pairs_shuffler.sv
// Fisher-Yates shuffle of a board of card pairs, driven by a free-running LFSR with
// rejection sampling of out-of-range indices.
module memory_pairs_shuffler
    import memory_pairs_pkg::*;
#(
    parameter int          NUM_PAIRS = 3,
    parameter int          VAL_W     = 4,
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEFAULT,
    localparam int         NUM_CARDS = 2 * NUM_PAIRS,
    localparam int         IDX_W     = clog2(NUM_CARDS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       restart,
    input  logic [IDX_W-1:0]           rd_idx,
    output logic [NUM_CARDS*VAL_W-1:0] cards,
    output logic [VAL_W-1:0]           rd_val,
    output logic                       busy,
    output logic                       end_state
);

    localparam logic [IDX_W-1:0] K_START = IDX_W'(NUM_CARDS - 1);
    localparam logic [IDX_W-1:0] K_ONE   = IDX_W'(1);

    logic [15:0]      lfsr;
    logic [IDX_W-1:0] r;
    state_e           state_q, state_d;
    logic [IDX_W-1:0] k_q, k_d;
    logic [VAL_W-1:0] cards_q [NUM_CARDS];
    logic [VAL_W-1:0] cards_d [NUM_CARDS];

    memory_lfsr #(
        .SEED(LFSR_SEED)
    ) u_lfsr (
        .clk(clk),
        .rst(rst),
        .q  (lfsr)
    );

    assign r = lfsr[IDX_W-1:0];

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        cards_d = cards_q;
        if (restart) begin
            k_d     = K_START;
            state_d = ST_SHUFFLE;
        end else if (state_q == ST_SHUFFLE && enable && r <= k_q) begin
            cards_d[k_q] = cards_q[r];
            cards_d[r]   = cards_q[k_q];
            k_d          = k_q - K_ONE;
            if (k_q == K_ONE) begin
                state_d = ST_DONE;
            end
        end
    end

    // NOTE: the board is deliberately reset; a blank or partial board must never survive rst.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SHUFFLE;
            k_q     <= K_START;
            for (int i = 0; i < NUM_CARDS; i++) begin
                cards_q[i] <= VAL_W'(i / 2 + 1);
            end
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cards_q <= cards_d;
        end
    end

    for (genvar g = 0; g < NUM_CARDS; g++) begin : g_flat
        assign cards[g*VAL_W +: VAL_W] = cards_q[g];
    end

    assign rd_val    = (int'(rd_idx) < NUM_CARDS) ? cards_q[rd_idx] : '0;
    assign busy      = (state_q == ST_SHUFFLE);
    assign end_state = (state_q == ST_DONE);

endmodule

// File: tb/tb_memory_pairs_shuffler.sv
// Randomized bench for memory_pairs_shuffler against a deck-level reference model (3 and 8 pairs).
module tb_memory_pairs_shuffler;

    localparam logic [15:0] SEED = 16'hACE1;
    localparam logic [15:0] TAPS = 16'hB400;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, en_a = 1'b0, rs_a = 1'b0;
    logic [2:0]  idx_a = '0;
    logic [23:0] cards_a;
    logic [3:0]  val_a;
    logic        busy_a, end_a;

    logic        rst_b = 1'b1, en_b = 1'b0, rs_b = 1'b0;
    logic [3:0]  idx_b = '0;
    logic [63:0] cards_b;
    logic [3:0]  val_b;
    logic        busy_b, end_b;

    memory_pairs_shuffler #(.NUM_PAIRS(3), .VAL_W(4)) dut_a (
        .clk(clk), .rst(rst_a), .enable(en_a), .restart(rs_a), .rd_idx(idx_a),
        .cards(cards_a), .rd_val(val_a), .busy(busy_a), .end_state(end_a)
    );

    memory_pairs_shuffler #(.NUM_PAIRS(8), .VAL_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .enable(en_b), .restart(rs_b), .rd_idx(idx_b),
        .cards(cards_b), .rd_val(val_b), .busy(busy_b), .end_state(end_b)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a deck of ints, the remaining-unshuffled boundary, and the LFSR word.
    int          sel;
    int          n;
    int          iw;
    int          m_cards [16];
    int          m_k;
    bit          m_done;
    int          m_swaps;
    logic [15:0] m_lfsr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] dut_board();
        return (sel == 0) ? {40'd0, cards_a} : cards_b;
    endfunction

    function automatic logic dut_busy();
        return (sel == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic dut_end();
        return (sel == 0) ? end_a : end_b;
    endfunction

    function automatic logic [3:0] dut_val();
        return (sel == 0) ? val_a : val_b;
    endfunction

    function automatic logic [63:0] model_board();
        logic [63:0] b;
        b = '0;
        for (int i = 0; i < n; i++) b[i*4 +: 4] = 4'(m_cards[i]);
        return b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < n; i++) m_cards[i] = i / 2 + 1;
        m_k    = n - 1;
        m_done = 1'b0;
        m_lfsr = SEED;
    endtask

    task automatic model_step(input bit en, input bit rs);
        int r;
        int tmp;
        r = int'(m_lfsr) & ((1 << iw) - 1);
        if (rs) begin
            m_k    = n - 1;
            m_done = 1'b0;
        end else if (!m_done && en && r <= m_k) begin
            tmp          = m_cards[m_k];
            m_cards[m_k] = m_cards[r];
            m_cards[r]   = tmp;
            m_swaps++;
            if (m_k == 1) m_done = 1'b1;
            m_k--;
        end
        m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ TAPS) : (m_lfsr >> 1);
    endtask

    task automatic drive(input bit en, input bit rs);
        if (sel == 0) begin
            en_a = en;
            rs_a = rs;
        end else begin
            en_b = en;
            rs_b = rs;
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [63:0] b;
        int          cnt [16];
        bit          ok;
        int          idx;
        int          expv;
        b = dut_board();
        check({tag, "/board"}, b, model_board());
        check({tag, "/busy"}, 64'(dut_busy()), 64'(!m_done));
        check({tag, "/end"}, 64'(dut_end()), 64'(m_done));
        for (int v = 0; v < 16; v++) cnt[v] = 0;
        for (int i = 0; i < n; i++) cnt[int'(b[i*4 +: 4])]++;
        ok = 1'b1;
        for (int v = 1; v <= n / 2; v++) if (cnt[v] != 2) ok = 1'b0;
        check({tag, "/pairs"}, 64'(ok), 64'(1));
        idx = $urandom_range(0, (1 << iw) - 1);
        if (sel == 0) idx_a = 3'(idx);
        else          idx_b = 4'(idx);
        #1;
        expv = (idx < n) ? m_cards[idx] : 0;
        check({tag, "/rd_val"}, 64'(dut_val()), 64'(expv));
    endtask

    task automatic cycle(input bit en, input bit rs, input string tag);
        drive(en, rs);
        model_step(en, rs);
        @(posedge clk);
        @(negedge clk);
        check_outputs(tag);
    endtask

    initial begin
        // ---------------- 3 pairs ----------------
        sel = 0; n = 6; iw = 3; m_swaps = 0;
        repeat (2) @(negedge clk);
        check("rst_board", {40'd0, cards_a}, 64'h332211);
        check("rst_busy", 64'(busy_a), 64'(1));
        check("rst_end", 64'(end_a), 64'(0));
        idx_a = 3'd4;
        #1 check("rst_rd4", 64'(val_a), 64'(3));
        idx_a = 3'd7;
        #1 check("rst_rd7", 64'(val_a), 64'(0));
        model_reset();
        check_outputs("rst");
        rst_a = 1'b0;

        for (int c = 0; c < 500 && !end_a; c++) cycle(1'b1, 1'b0, "run");
        check("run_done", 64'(end_a), 64'(1));
        repeat (4) cycle(1'b1, 1'b0, "done_hold_en");
        repeat (2) cycle(1'b0, 1'b0, "done_hold");

        cycle(1'b0, 1'b1, "restart_done");
        repeat (3) cycle(1'b1, 1'b0, "reshuffle");
        cycle(1'b1, 1'b1, "restart_en");

        for (int p = 0; p < 6; p++) begin
            repeat (8) cycle(1'b1, 1'b0, "tog_hi");
            repeat (8) cycle(1'b0, 1'b0, "tog_lo");
        end

        repeat (300) cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 19) == 0), "rand");

        cycle(1'b0, 1'b1, "pre_rst");
        m_swaps = 0;
        for (int c = 0; c < 200 && m_swaps < 2; c++) cycle(1'b1, 1'b0, "two_swaps");
        drive(1'b0, 1'b0);
        #2 rst_a = 1'b1;
        #1;
        check("async_rst_board", {40'd0, cards_a}, 64'h332211);
        check("async_rst_busy", 64'(busy_a), 64'(1));
        check("async_rst_end", 64'(end_a), 64'(0));
        model_reset();
        @(negedge clk);
        check_outputs("in_rst");
        rst_a = 1'b0;
        for (int c = 0; c < 500 && !end_a; c++) cycle(1'b1, 1'b0, "after_rst");
        check("after_rst_done", 64'(end_a), 64'(1));

        // ---------------- 8 pairs ----------------
        sel = 1; n = 16; iw = 4;
        @(negedge clk);
        check("b_rst_board", cards_b, 64'h8877665544332211);
        idx_b = 4'd15;
        #1 check("b_rst_rd15", 64'(val_b), 64'(8));
        model_reset();
        check_outputs("b_rst");
        rst_b = 1'b0;
        for (int c = 0; c < 3000 && !end_b; c++) cycle(1'($urandom_range(0, 3) != 0), 1'b0, "b_run");
        check("b_done", 64'(end_b), 64'(1));
        repeat (4) cycle(1'b1, 1'b0, "b_hold");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
